// File: rtl/barrett_sched_if.sv
// Bundle of requester, reducer and result signals for barrett_sched.
//   slave  : the scheduler side (takes operands and red_r, drives grants,
//            red_c, results and status)
//   master : the environment side (requesters, reducer, result consumers)
//   req_valid/req_data/req_ready : per-requester operand handshake
//   red_c/red_r                  : operand to and result from the shared reducer
//   res_valid/res_data           : result routed back to one requester
//   busy/err                     : activity and sticky range-error status
interface barrett_sched_if #(
    parameter int N = 4
);
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [31:0]     red_c;
    logic [15:0]     red_r;
    logic [N-1:0]    res_valid;
    logic [15:0]     res_data;
    logic            busy;
    logic            err;

    modport slave (
        input  req_valid, req_data, red_r,
        output req_ready, red_c, res_valid, res_data, busy, err
    );

    modport master (
        output req_valid, req_data, red_r,
        input  req_ready, red_c, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/barrett_sched.sv
// Shares one pipelined Barrett reducer (mod 3329) among N requesters.
// Round-robin arbitration with bursts of at most MAX_BURST accepts, a
// registered reducer operand, a LAT-deep in-flight tag pipe and a registered
// result tag that steers the reducer output back to its requester.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   flush : drop every in-flight op and return to arbitration
//   bus   : barrett_sched_if slave (handshake, reducer, results, status)
module barrett_sched #(
    parameter int N         = 4,
    parameter int LAT       = 2,
    parameter int MAX_BURST = 8,
    parameter int MAX_IN    = 67108864
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    barrett_sched_if.slave   bus
);
    localparam int IW = $clog2(N);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [31:0]     red_c_q, red_c_d;
    logic            err_q, err_d;
    logic [LAT-1:0]  tag_v_q, tag_v_d;
    logic [IW-1:0]   tag_i_q [LAT];
    logic [IW-1:0]   tag_i_d [LAT];
    logic [N-1:0]    res_valid_q, res_valid_d;

    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   cand;
    logic            grant_en;
    logic [IW-1:0]   grant_idx;
    logic            accept;
    logic [31:0]     grant_data;

    // Round-robin search: first valid requester at or above rr_q, wrapping mod N.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        arb_found = 1'b0;
        arb_idx   = rr_q;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(rr_q) + k) % N);
            if (!arb_found && bus.req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // FSM output process: grant is combinational so an ARB cycle can accept.
    always_comb begin
        grant_en  = 1'b0;
        grant_idx = owner_q;
        unique case (state_q)
            ARB: begin
                grant_en  = arb_found;
                grant_idx = arb_idx;
            end
            HOLD: begin
                grant_en  = bus.req_valid[owner_q] && (burst_q < BW'(MAX_BURST));
                grant_idx = owner_q;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = grant_en ? (N'(1) << grant_idx) : '0;
    // flush wins over a same-cycle handshake: nothing is issued that cycle.
    assign accept     = grant_en && bus.req_valid[grant_idx] && !flush;
    assign grant_data = bus.req_data[{grant_idx, 5'b0} +: 32];

    // FSM next-state process. In HOLD, a missing accept means either the owner
    // dropped valid or its burst is used up; both hand the pointer onward.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        if (flush) begin
            state_d = ARB;
            burst_d = '0;
        end else begin
            unique case (state_q)
                ARB: begin
                    if (accept) begin
                        state_d = HOLD;
                        owner_d = grant_idx;
                        burst_d = BW'(1);
                    end
                end
                HOLD: begin
                    if (accept) begin
                        burst_d = burst_q + BW'(1);
                    end else begin
                        state_d = ARB;
                        rr_d    = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
                        burst_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: operand register, sticky range error, tag pipe, result tag.
    always_comb begin
        red_c_d = accept ? grant_data : red_c_q;
        err_d   = err_q || (accept && (grant_data >= 32'(MAX_IN)));
        tag_v_d = '0;
        tag_i_d = tag_i_q;
        tag_v_d[0] = accept;
        tag_i_d[0] = grant_idx;
        for (int s = 1; s < LAT; s++) begin
            tag_v_d[s] = tag_v_q[s-1];
            tag_i_d[s] = tag_i_q[s-1];
        end
        // The last stage lines up with red_r one cycle later, hence the extra register.
        res_valid_d = tag_v_q[LAT-1] ? (N'(1) << tag_i_q[LAT-1]) : '0;
        if (flush) begin
            tag_v_d     = '0;
            res_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ARB;
            owner_q     <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            red_c_q     <= '0;
            err_q       <= 1'b0;
            tag_v_q     <= '0;
            res_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
            red_c_q     <= red_c_d;
            err_q       <= err_d;
            tag_v_q     <= tag_v_d;
            res_valid_q <= res_valid_d;
        end
    end

    // NOTE: tag indices need no reset; they are only observed when the matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_i_q <= tag_i_d;
    end

    assign bus.red_c     = red_c_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = bus.red_r;
    assign bus.busy      = (|bus.req_valid) || (|tag_v_q);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_barrett_sched.sv
// Directed bench for barrett_sched: a behavioural two-stage mod-3329 reducer,
// a scoreboard of expected (tag, value, accept cycle) entries, and a linear
// sequence of scenarios covering fairness, single, burst, wrap, flush,
// range error and reset.
module tb_barrett_sched;
    localparam int N         = 4;
    localparam int LAT       = 2;
    localparam int MAX_BURST = 8;
    localparam int Q         = 3329;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    barrett_sched_if #(.N(N)) bus();

    barrett_sched #(
        .N(N), .LAT(LAT), .MAX_BURST(MAX_BURST), .MAX_IN(67108864)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reducer model: value valid LAT=2 edges after red_c changes.
    logic [15:0] r1 = '0;
    logic [15:0] r2 = '0;
    always @(posedge clk) begin
        r1 <= 16'(bus.red_c % Q);
        r2 <= r1;
    end
    assign bus.red_r = r2;

    typedef struct {
        int unsigned tag;
        int unsigned data;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int i, input logic [31:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_data[32*i +: 32] = d;
    endtask

    task automatic idle();
        bus.req_valid = '0;
    endtask

    // One clock: record accepts into the scoreboard, clock, then compare any result.
    task automatic cycle();
        logic [N-1:0] acc;
        exp_t e;
        #1;
        acc = bus.req_valid & bus.req_ready & {N{~flush}};
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                e.tag  = i;
                e.data = bus.req_data[32*i +: 32] % Q;
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        if (rst || flush) sb.delete();
        #1;
        if (bus.res_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 64'(bus.res_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("res_tag", 64'(bus.res_valid), 64'(1) << e.tag);
                check("res_data", 64'(bus.res_data), 64'(e.data));
                check("res_latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3; i++) cycle();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [N-1:0] exp_rdy;
        bus.req_valid = '0;
        bus.req_data  = '0;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_red_c", 64'(bus.red_c), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);

        // Fairness: all valid, bursts of 8 with one gap per switch
        for (int t = 0; t < 36; t++) begin
            for (int i = 0; i < N; i++) drive(i, 32'($urandom_range(67108863, 0)));
            #1;
            exp_rdy = ((t % 9) < 8) ? (N'(1) << ((t / 9) % 4)) : '0;
            check("fair_grant", 64'(bus.req_ready), 64'(exp_rdy));
            cycle();
        end
        idle();
        drain("fair_drained");

        // Single op from requester 0
        drive(0, 32'd33295);
        #1;
        check("single_ready", 64'(bus.req_ready), 64'b0001);
        cycle();
        idle();
        #1;
        check("single_busy", 64'(bus.busy), 64'd1);
        check("single_red_c", 64'(bus.red_c), 64'd33295);
        drain("single_drained");

        // Burst from requester 1, back-to-back results
        drive(1, 32'd33299);
        #1;
        check("burst_ready", 64'(bus.req_ready), 64'b0010);
        cycle();
        drive(1, 32'd10);
        cycle();
        drive(1, 32'd8380418);
        cycle();
        idle();
        drain("burst_drained");

        // Move pointer to 3, then only requester 0: wrap-around grant in ARB
        drive(2, 32'd100);
        cycle();
        idle();
        cycle();
        drive(0, 32'd7);
        #1;
        check("wrap_grant", 64'(bus.req_ready), 64'b0001);
        cycle();
        idle();
        drain("wrap_drained");

        // Flush with ops in flight; flush also beats a same-cycle handshake
        drive(1, 32'd1000);
        cycle();
        drive(1, 32'd2000);
        cycle();
        drive(1, 32'd3000);
        cycle();
        drive(1, 32'd3500);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        #1;
        check("flush_res_valid", 64'(bus.res_valid), 64'd0);
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_red_c", 64'(bus.red_c), 64'd3000);
        cycle();
        check("flush_quiet_1", 64'(bus.res_valid), 64'd0);
        cycle();
        check("flush_quiet_2", 64'(bus.res_valid), 64'd0);
        drive(2, 32'd4000);
        cycle();
        idle();
        drain("flush_drained");

        // Range error at the boundary, sticky
        drive(3, 32'h03FF_FFFF);
        cycle();
        #1;
        check("err_below", 64'(bus.err), 64'd0);
        drive(3, 32'h0400_0000);
        cycle();
        idle();
        #1;
        check("err_set", 64'(bus.err), 64'd1);
        drain("err_drained");
        check("err_sticky", 64'(bus.err), 64'd1);

        // Reset with ops in flight
        drive(0, 32'd123);
        cycle();
        drive(0, 32'd456);
        cycle();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("midrst_res_valid", 64'(bus.res_valid), 64'd0);
        check("midrst_ready", 64'(bus.req_ready), 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_red_c", 64'(bus.red_c), 64'd0);
        cycle();
        check("midrst_quiet", 64'(bus.res_valid), 64'd0);
        drain("midrst_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
